// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- definitions shared by the UART transmitter and receiver.
//
// Contents:
//   OVERSAMPLE       baud ticks per serial bit (16x oversampling)
//   DEFAULT_NB_DATA  default data bits per frame
//   DEFAULT_SB_TICK  default stop length in ticks (16 = 1 stop bit)
//   tx_state_t       transmitter FSM state encoding (binary)
//   baud_div()       clocks per oversampling tick
//
// Optional feature macro: UART_TX_PARITY_EN adds the ST_PARITY state.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE      = 16;
    localparam int DEFAULT_NB_DATA = 8;
    localparam int DEFAULT_SB_TICK = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } tx_state_t;

    // Clocks between oversampling ticks; truncating division.
    function automatic int baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / (baud_rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/baud_rate_gen.sv
// -----------------------------------------------------------------------------
// baud_rate_gen -- free-running oversampling tick generator.
//
// A counter runs 0..DIV-1 and wraps; each wrap produces a registered
// one-cycle pulse, so o_tick has period DIV = CLK_FREQ/(BAUD_RATE*16).
// Shared between the UART transmitter and receiver.
//
// Parameters: CLK_FREQ (Hz), BAUD_RATE (bit/s); DIV must be at least 1.
// Ports:
//   i_clock  in   clock, rising edge
//   i_reset  in   asynchronous active-high reset
//   o_tick   out  one-cycle tick every DIV clocks
// -----------------------------------------------------------------------------
module baud_rate_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_tick
);

    localparam int DIV   = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Divider counter and registered tick pulse on each wrap.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            tick_r <= 1'b0;
        end
    end

    assign o_tick = tick_r;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART serial transmitter, LSB first, 16x oversampled bit timing.
//
// Frame: start bit (0), NB_DATA data bits, optional even parity bit,
// stop time of SB_TICK ticks (high). A request (i_tx_start level) is
// accepted only in IDLE when o_tx_done is low, so a requester holding
// i_tx_start high gets one done cycle to advance its data before the
// next frame is accepted; frames then run with two IDLE clocks between.
//
// Parameters: NB_DATA, SB_TICK, CLK_FREQ, BAUD_RATE.
// Ports:
//   i_clock     in   clock, rising edge
//   i_reset     in   asynchronous active-high reset (aborts a frame)
//   i_tx_start  in   level request to send i_tx_data
//   i_tx_data   in   byte to send, latched on acceptance
//   o_tx        out  serial line, idle high, registered
//   o_tx_done   out  one-cycle pulse in the first IDLE cycle after stop
//   o_tx_busy   out  high from acceptance through the last stop tick
//
// Optional feature macro: UART_TX_PARITY_EN inserts an even parity bit
// between the data bits and the stop time.
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int NB_DATA   = DEFAULT_NB_DATA,
    parameter int SB_TICK   = DEFAULT_SB_TICK,
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_tx_data,
    output logic               o_tx,
    output logic               o_tx_done,
    output logic               o_tx_busy
);

    // Tick counter covers both the 16-tick bit time and the stop time.
    localparam int TICK_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
    localparam int BIT_W  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST_BIT  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_LAST_STOP = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST       = BIT_W'(NB_DATA - 1);

    tx_state_t          state_r,    state_s;
    logic [TICK_W-1:0]  tick_cnt_r, tick_cnt_s;
    logic [BIT_W-1:0]   bit_cnt_r,  bit_cnt_s;
    logic [NB_DATA-1:0] shreg_r,    shreg_s;
    logic               tx_r,       tx_s;
    logic               done_r,     done_s;
    logic               busy_r,     busy_s;
    logic               baud_tick_s;

`ifdef UART_TX_PARITY_EN
    logic               parity_r,   parity_s;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [NB_DATA-1:0] data);
        return ^data;
    endfunction
`endif

    baud_rate_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_baud_rate_gen (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .o_tick  (baud_tick_s)
    );

    // Next-state, counter, shift-register and flag logic.
    always_comb begin
        state_s    = state_r;
        tick_cnt_s = tick_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shreg_s    = shreg_r;
        done_s     = 1'b0;
        busy_s     = busy_r;
`ifdef UART_TX_PARITY_EN
        parity_s   = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                // done_r blocks acceptance during the done cycle.
                if (i_tx_start && !done_r) begin
                    state_s    = ST_START;
                    shreg_s    = i_tx_data;
                    tick_cnt_s = '0;
                    bit_cnt_s  = '0;
                    busy_s     = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_s   = even_parity(i_tx_data);
`endif
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_START: begin
                if (baud_tick_s) begin
                    if (tick_cnt_r == TICK_LAST_BIT) begin
                        state_s    = ST_DATA;
                        tick_cnt_s = '0;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_W'(1);
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            ST_DATA: begin
                if (baud_tick_s) begin
                    if (tick_cnt_r == TICK_LAST_BIT) begin
                        tick_cnt_s = '0;
                        shreg_s    = shreg_r >> 1;
                        if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_s = ST_PARITY;
`else
                            state_s = ST_STOP;
`endif
                        end else begin
                            bit_cnt_s = bit_cnt_r + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_W'(1);
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick_s) begin
                    if (tick_cnt_r == TICK_LAST_BIT) begin
                        state_s    = ST_STOP;
                        tick_cnt_s = '0;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_W'(1);
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick_s) begin
                    if (tick_cnt_r == TICK_LAST_STOP) begin
                        state_s    = ST_IDLE;
                        tick_cnt_s = '0;
                        done_s     = 1'b1;
                        busy_s     = 1'b0;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_W'(1);
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Line level follows the state being entered so o_tx changes with it.
    always_comb begin
        tx_s = 1'b1;
        case (state_s)
            ST_IDLE:   tx_s = 1'b1;
            ST_START:  tx_s = 1'b0;
            ST_DATA:   tx_s = shreg_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_s = parity_s;
`endif
            ST_STOP:   tx_s = 1'b1;
            default:   tx_s = 1'b1;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shreg_r    <= '0;
            tx_r       <= 1'b1;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            tick_cnt_r <= tick_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shreg_r    <= shreg_s;
            tx_r       <= tx_s;
            done_r     <= done_s;
            busy_r     <= busy_s;
`ifdef UART_TX_PARITY_EN
            parity_r   <= parity_s;
`endif
        end
    end

    assign o_tx      = tx_r;
    assign o_tx_done = done_r;
    assign o_tx_busy = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- scoreboard bench for uart_tx.
//
// Two DUTs: SB_TICK=16 and SB_TICK=32, both at DIV=10 clocks per tick
// (160 clocks per bit). Stimulus pushes the expected byte into a per-DUT
// queue; a monitor per DUT decodes each frame at bit centres, pops on the
// done pulse and checks bits, frame duration and back-to-back spacing.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CLK_FREQ  = 1600000;
    localparam int BAUD_RATE = 10000;
    localparam int DIV       = 10;
    localparam int OVS       = 16;
    localparam int BIT       = OVS * DIV;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS  = 1;
`else
    localparam int PAR_BITS  = 0;
`endif
    localparam int NSAMP     = 1 + 8 + PAR_BITS + 1;

    typedef struct packed {
        logic [7:0] data;
        logic       b2b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [7:0] data0, data1;
    logic       tx0, done0, busy0;
    logic       tx1, done1, busy1;

    exp_t   q0[$];
    exp_t   q1[$];
    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.NB_DATA(8), .SB_TICK(16), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut0 (
        .i_clock(clk), .i_reset(rst), .i_tx_start(start0), .i_tx_data(data0),
        .o_tx(tx0), .o_tx_done(done0), .o_tx_busy(busy0)
    );

    uart_tx #(.NB_DATA(8), .SB_TICK(32), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_tx_start(start1), .i_tx_data(data1),
        .o_tx(tx1), .o_tx_done(done1), .o_tx_busy(busy1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic tx_of(input int w);
        return (w == 0) ? tx0 : tx1;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 0) ? done0 : done1;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 0) ? busy0 : busy1;
    endfunction

    function automatic int q_size(input int w);
        return (w == 0) ? q0.size() : q1.size();
    endfunction

    task automatic q_pop(input int w, output exp_t r);
        if (w == 0) r = q0.pop_front();
        else        r = q1.pop_front();
    endtask

    // Line image, index 0 = start bit, LSB of data first.
    function automatic logic [NSAMP-1:0] frame_bits(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    task automatic monitor(input int w);
        int               sb, off, done_off, idx, t_exp;
        longint           fall_c, last_done_c;
        logic             prev_tx;
        bit               aborted;
        logic [NSAMP-1:0] got;
        exp_t             e;
        sb          = (w == 0) ? 16 : 32;
        t_exp       = (OVS + OVS * 8 + OVS * PAR_BITS + sb) * DIV;
        last_done_c = -1000;
        prev_tx     = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && done_of(w))
                check($sformatf("spurious_done%0d", w), done_of(w), 1'b0);
            if (!rst && prev_tx && !tx_of(w)) begin
                fall_c   = cyc;
                off      = 0;
                done_off = -1;
                aborted  = 1'b0;
                got      = '0;
                while (done_off < 0 && !aborted) begin
                    @(negedge clk);
                    off++;
                    if (rst) begin
                        aborted = 1'b1;
                    end else if (done_of(w)) begin
                        done_off = off;
                    end else if (off > t_exp + 4 * BIT) begin
                        check($sformatf("frame_timeout%0d", w), done_of(w), 1'b1);
                        aborted = 1'b1;
                    end else if (off >= BIT / 2 && (off - BIT / 2) % BIT == 0) begin
                        idx = (off - BIT / 2) / BIT;
                        if (idx < NSAMP) got[idx] = tx_of(w);
                        if (idx == 0) check($sformatf("busy_in_frame%0d", w), busy_of(w), 1'b1);
                    end
                end
                if (done_off >= 0) begin
                    check($sformatf("busy_in_done%0d", w), busy_of(w), 1'b0);
                    if (q_size(w) == 0) begin
                        check($sformatf("unexpected_frame%0d", w), q_size(w), 1);
                    end else begin
                        q_pop(w, e);
                        check($sformatf("frame%0d_%02h", w, e.data), got, frame_bits(e.data));
                        check_range($sformatf("frame_len%0d_%02h", w, e.data), done_off,
                                    t_exp - DIV + 1, t_exp);
                        if (e.b2b)
                            check($sformatf("idle_gap%0d_%02h", w, e.data), fall_c - last_done_c, 2);
                    end
                    last_done_c = cyc;
                    @(negedge clk);
                    if (!rst) check($sformatf("done_width%0d", w), done_of(w), 1'b0);
                end
            end
            prev_tx = rst ? 1'b1 : tx_of(w);
        end
    endtask

    task automatic wait_done(input int w);
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (done_of(w)) return;
        end
        check($sformatf("wait_done%0d", w), done_of(w), 1'b1);
    endtask

    task automatic pulse0(input logic [7:0] d);
        data0  = d;
        start0 = 1'b1;
        q0.push_back('{data: d, b2b: 1'b0});
        @(negedge clk);
        start0 = 1'b0;
        check("busy_after_accept", busy0, 1'b1);
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
        join_none
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        data0  = 8'h00;
        data1  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx",   tx0,   1'b1);
        check("reset_done", done0, 1'b0);
        check("reset_busy", busy0, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame 0xA5: line 0,1,0,1,0,0,1,0,1,1.
        pulse0(8'hA5);
        wait_done(0);
        repeat (2) @(negedge clk);

        // Start held high, data advanced in the done cycle.
        data0  = 8'h01;
        start0 = 1'b1;
        q0.push_back('{data: 8'h01, b2b: 1'b0});
        wait_done(0);
        data0 = 8'h02;
        q0.push_back('{data: 8'h02, b2b: 1'b1});
        wait_done(0);
        start0 = 1'b0;
        repeat (2) @(negedge clk);

        // Data changed mid-frame must not reach the line.
        pulse0(8'h3C);
        repeat (3 * BIT) @(negedge clk);
        data0 = 8'hFF;
        wait_done(0);

        // A request seen only in the done cycle is ignored.
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        check("done_cycle_start_busy", busy0, 1'b0);
        check("done_cycle_start_tx",   tx0,   1'b1);

        // Parity vectors (odd and even ones count).
        pulse0(8'h07);
        wait_done(0);
        repeat (2) @(negedge clk);
        pulse0(8'h03);
        wait_done(0);
        repeat (2) @(negedge clk);

        // Reset in the middle of a start bit aborts without a clock edge.
        data0  = 8'h5A;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (BIT / 2) @(negedge clk);
        check("pre_reset_tx", tx0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_reset_tx",   tx0,   1'b1);
        check("async_reset_done", done0, 1'b0);
        check("async_reset_busy", busy0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        check("no_restart_busy", busy0, 1'b0);
        check("no_restart_tx",   tx0,   1'b1);

        // Two stop bits on the second instance.
        data1  = 8'h96;
        start1 = 1'b1;
        q1.push_back('{data: 8'h96, b2b: 1'b0});
        @(negedge clk);
        start1 = 1'b0;
        check("busy1_after_accept", busy1, 1'b1);
        wait_done(1);
        repeat (4) @(negedge clk);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
